// File: rtl/pc_gen.sv
// +----------------------------------------------------------------------------+
// | pc_gen : fetch-address generator with valid/ready issue and redirect buffer |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_gen #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = 'h80000000,
  parameter int                 STEP         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jb_i,
  input  logic [ADDR_W-1:0] dnpc_i,
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              req_ready_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              misalign_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_STALL = 2'd2;
  localparam logic [1:0] c_HALT  = 2'd3;

  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] c_STEP       = ADDR_W'(STEP);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_trap_q, pend_trap_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              mis_q, mis_d;

  logic              w_redir;
  logic [ADDR_W-1:0] w_redir_tgt;

  // A trap in the same cycle as a branch wins; the branch is dropped.
  assign w_redir     = trap_i | jb_i;
  assign w_redir_tgt = trap_i ? trap_vec_i : dnpc_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_v_d    = pend_v_q;
    pend_trap_d = pend_trap_q;
    pend_tgt_d  = pend_tgt_q;
    mis_d       = 1'b0;

    case (state_q)
      c_IDLE: begin
        state_d = c_FETCH;
      end

      c_FETCH: begin
        if (req_ready_i) begin
          pend_v_d = 1'b0;
          if (w_redir) begin
            pc_d  = w_redir_tgt & ~c_ALIGN_MASK;
            mis_d = |(w_redir_tgt & c_ALIGN_MASK);
          end else if (pend_v_q) begin
            pc_d  = pend_tgt_q & ~c_ALIGN_MASK;
            mis_d = |(pend_tgt_q & c_ALIGN_MASK);
          end else begin
            pc_d = pc_q + c_STEP;
          end
          if (halt_i) begin
            state_d = c_HALT;
          end else if (stall_i) begin
            state_d = c_STALL;
          end
        end else begin
          // Request still outstanding: remember the redirect; a pending trap is never displaced by a branch.
          if (trap_i) begin
            pend_v_d    = 1'b1;
            pend_trap_d = 1'b1;
            pend_tgt_d  = trap_vec_i;
          end else if (jb_i && !(pend_v_q && pend_trap_q)) begin
            pend_v_d    = 1'b1;
            pend_trap_d = 1'b0;
            pend_tgt_d  = dnpc_i;
          end
        end
      end

      c_STALL: begin
        if (w_redir) begin
          pc_d  = w_redir_tgt & ~c_ALIGN_MASK;
          mis_d = |(w_redir_tgt & c_ALIGN_MASK);
        end
        if (halt_i) begin
          state_d  = c_HALT;
          pend_v_d = 1'b0;
        end else if (!stall_i) begin
          state_d = c_FETCH;
        end
      end

      default: begin
        state_d = c_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_IDLE;
      pc_q        <= RESET_VECTOR;
      pend_v_q    <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_tgt_q  <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_trap_q <= pend_trap_d;
      pend_tgt_q  <= pend_tgt_d;
      mis_q       <= mis_d;
    end
  end

  assign req_valid_o = (state_q == c_FETCH);
  assign ce_o        = (state_q == c_FETCH) || (state_q == c_STALL);
  assign pc_o        = pc_q;
  assign misalign_o  = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// +----------------------------------------------------------------------------+
// | tb_pc_gen : directed + random checks of pc_gen (STEP=4 and STEP=2 copies)  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_gen;

  localparam logic [31:0] c_RV = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst, jb, trap, stall, halt, ready;
  logic [31:0] dnpc, tv;

  logic [31:0] pc4, pc2;
  logic        v4, v2, ce4, ce2, m4, m2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: [0] models STEP=4, [1] models STEP=2.
  int          m_step [2] = '{4, 2};
  bit          m_started [2], m_stall [2], m_halt [2], m_pv [2], m_pt [2], m_mis [2];
  logic [31:0] m_pc [2], m_ptgt [2];
  bit          n_started [2], n_stall [2], n_halt [2], n_pv [2], n_pt [2], n_mis [2];
  logic [31:0] n_pc [2], n_ptgt [2];

  pc_gen #(.ADDR_W(32), .RESET_VECTOR(c_RV), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .jb_i(jb), .dnpc_i(dnpc), .trap_i(trap), .trap_vec_i(tv),
    .stall_i(stall), .halt_i(halt), .req_ready_i(ready),
    .req_valid_o(v4), .pc_o(pc4), .ce_o(ce4), .misalign_o(m4)
  );

  pc_gen #(.ADDR_W(32), .RESET_VECTOR(c_RV), .STEP(2)) u_dut2 (
    .clk(clk), .rst(rst), .jb_i(jb), .dnpc_i(dnpc), .trap_i(trap), .trap_vec_i(tv),
    .stall_i(stall), .halt_i(halt), .req_ready_i(ready),
    .req_valid_o(v2), .pc_o(pc2), .ce_o(ce2), .misalign_o(m2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Round the target down to a multiple of the step and note whether rounding happened.
  task automatic apply(input int k, input logic [31:0] t);
    n_pc[k]  = t - (t % m_step[k]);
    n_mis[k] = (t % m_step[k]) != 0;
  endtask

  task automatic model_next();
    for (int k = 0; k < 2; k++) begin
      n_started[k] = m_started[k]; n_stall[k] = m_stall[k]; n_halt[k] = m_halt[k];
      n_pv[k] = m_pv[k]; n_pt[k] = m_pt[k]; n_ptgt[k] = m_ptgt[k]; n_pc[k] = m_pc[k];
      n_mis[k] = 1'b0;
      if (rst) begin
        n_started[k] = 0; n_stall[k] = 0; n_halt[k] = 0; n_pv[k] = 0; n_pc[k] = c_RV;
      end else if (!m_started[k]) begin
        n_started[k] = 1;
      end else if (m_halt[k]) begin
        n_pc[k] = m_pc[k];
      end else if (m_stall[k]) begin
        if (trap) apply(k, tv);
        else if (jb) apply(k, dnpc);
        if (halt) begin n_halt[k] = 1; n_pv[k] = 0; end
        else if (!stall) n_stall[k] = 0;
      end else if (ready) begin
        n_pv[k] = 0;
        if (trap) apply(k, tv);
        else if (jb) apply(k, dnpc);
        else if (m_pv[k]) apply(k, m_ptgt[k]);
        else n_pc[k] = m_pc[k] + 32'(m_step[k]);
        if (halt) n_halt[k] = 1;
        else if (stall) n_stall[k] = 1;
      end else begin
        if (trap) begin
          n_pv[k] = 1; n_pt[k] = 1; n_ptgt[k] = tv;
        end else if (jb && !(m_pv[k] && m_pt[k])) begin
          n_pv[k] = 1; n_pt[k] = 0; n_ptgt[k] = dnpc;
        end
      end
    end
  endtask

  task automatic cyc();
    model_next();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_started[k] = n_started[k]; m_stall[k] = n_stall[k]; m_halt[k] = n_halt[k];
      m_pv[k] = n_pv[k]; m_pt[k] = n_pt[k]; m_ptgt[k] = n_ptgt[k];
      m_pc[k] = n_pc[k]; m_mis[k] = n_mis[k];
    end
    jb   = 1'b0;
    trap = 1'b0;
    chk("s4_pc",    pc4, m_pc[0]);
    chk("s4_valid", 32'(v4),  32'(m_started[0] && !m_stall[0] && !m_halt[0]));
    chk("s4_ce",    32'(ce4), 32'(m_started[0] && !m_halt[0]));
    chk("s4_mis",   32'(m4),  32'(m_mis[0]));
    chk("s2_pc",    pc2, m_pc[1]);
    chk("s2_valid", 32'(v2),  32'(m_started[1] && !m_stall[1] && !m_halt[1]));
    chk("s2_ce",    32'(ce2), 32'(m_started[1] && !m_halt[1]));
    chk("s2_mis",   32'(m2),  32'(m_mis[1]));
  endtask

  initial begin
    rst = 1'b1; jb = 1'b0; trap = 1'b0; stall = 1'b0; halt = 1'b0; ready = 1'b0;
    dnpc = '0; tv = '0;
    for (int k = 0; k < 2; k++) begin
      m_started[k] = 0; m_stall[k] = 0; m_halt[k] = 0; m_pv[k] = 0; m_pt[k] = 0;
      m_mis[k] = 0; m_pc[k] = c_RV; m_ptgt[k] = '0;
    end
    #1;
    cyc(); cyc();
    chk("rst_pc", pc4, c_RV);
    chk("rst_valid", 32'(v4), 32'd0);
    chk("rst_ce", 32'(ce4), 32'd0);

    // Sequential fetch from the reset vector.
    rst = 1'b0; ready = 1'b1;
    cyc();
    chk("seq0", pc4, 32'h80000000);
    chk("seq_ce", 32'(ce4), 32'd1);
    cyc(); chk("seq1", pc4, 32'h80000004);
    cyc(); chk("seq2", pc4, 32'h80000008);

    // Branch while the request is stalled by memory.
    ready = 1'b0; jb = 1'b1; dnpc = 32'h80000100;
    cyc(); cyc(); cyc();
    chk("hold_pc", pc4, 32'h80000008);
    ready = 1'b1;
    cyc(); chk("late_br", pc4, 32'h80000100);

    // Trap and branch together with handshake.
    trap = 1'b1; tv = 32'h80000200; jb = 1'b1; dnpc = 32'h80000100;
    cyc(); chk("trap_wins", pc4, 32'h80000200);

    // Pending trap survives a later branch.
    ready = 1'b0; trap = 1'b1; tv = 32'h80000200;
    cyc();
    jb = 1'b1; dnpc = 32'h80000100;
    cyc();
    ready = 1'b1;
    cyc(); chk("pend_trap", pc4, 32'h80000200);

    // Misaligned target.
    jb = 1'b1; dnpc = 32'h80000102;
    cyc();
    chk("mis4_pc", pc4, 32'h80000100);
    chk("mis4_pulse", 32'(m4), 32'd1);
    chk("mis2_pc", pc2, 32'h80000102);
    chk("mis2_pulse", 32'(m2), 32'd0);
    cyc(); chk("mis4_drop", 32'(m4), 32'd0);

    // Address wrap.
    jb = 1'b1; dnpc = 32'hFFFFFFFC;
    cyc(); chk("wrap_pre", pc4, 32'hFFFFFFFC);
    cyc(); chk("wrap", pc4, 32'h00000000);

    // Stall after handshake, then release.
    stall = 1'b1;
    cyc(); chk("stall_valid", 32'(v4), 32'd0);
    chk("stall_pc", pc4, 32'h00000004);
    cyc();
    stall = 1'b0;
    cyc(); chk("resume_valid", 32'(v4), 32'd1);
    chk("resume_pc", pc4, 32'h00000004);
    cyc(); chk("resume_next", pc4, 32'h00000008);

    // Halt, frozen, then reset.
    halt = 1'b1;
    cyc(); chk("halt_ce", 32'(ce4), 32'd0);
    halt = 1'b0; jb = 1'b1; dnpc = 32'h80000400;
    cyc(); cyc();
    chk("halt_pc", pc4, 32'h0000000C);
    rst = 1'b1;
    cyc(); chk("rst_again", pc4, c_RV);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      ready = ($urandom_range(0, 2) != 0);
      stall = ($urandom_range(0, 4) == 0);
      halt  = ($urandom_range(0, 199) == 0);
      jb    = ($urandom_range(0, 5) == 0);
      trap  = ($urandom_range(0, 11) == 0);
      dnpc  = $urandom;
      tv    = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
